vc_buffer_ctrl: RTL and testbench

Per-virtual-channel controller in the router input port. It sequences reads from one circular_buffer instance: it detects a head flit at the buffer front, latches its route, requests and holds a downstream VC through VC allocation, then requests switch allocation flit by flit. On each switch grant it pops the buffer and presents the flit, tagged with the allocated VC, to the crossbar. It returns to idle after a TAIL or HEADTAIL flit.

---
 rtl/noc_params.sv | 50 +++++
 rtl/vc_buffer_ctrl.sv | 132 +++++++++++++
 tb/tb_vc_buffer_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/noc_params.sv
// Shared NoC router types and sizing.
// Holds the flit label encoding, flit payloads (with and without VC tag),
// port/VC id types, the per-VC controller state encoding and the sizing constants.
package noc_params;

  localparam int unsigned VC_SIZE       = 2;
  localparam int unsigned PORT_NUM      = 5;
  localparam int unsigned MAX_PKT_FLITS = 16;
  localparam int unsigned DATA_W        = 16;

  localparam int unsigned VC_ID_W   = (VC_SIZE > 1) ? $clog2(VC_SIZE) : 1;
  localparam int unsigned PORT_W    = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
  localparam int unsigned PKT_CNT_W = $clog2(MAX_PKT_FLITS + 1);

  typedef logic [PORT_W-1:0]  port_t;
  typedef logic [VC_ID_W-1:0] vc_id_t;

  typedef enum logic [1:0] {
    HEAD     = 2'd0,
    BODY     = 2'd1,
    TAIL     = 2'd2,
    HEADTAIL = 2'd3
  } flit_label_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VA     = 2'd1,
    ACTIVE = 2'd2
  } vc_state_t;

  typedef struct packed {
    flit_label_t       label;
    logic [DATA_W-1:0] data;
  } flit_novc_t;

  typedef struct packed {
    flit_label_t       label;
    vc_id_t            vc_id;
    logic [DATA_W-1:0] data;
  } flit_t;

  function automatic logic is_head(input flit_label_t l);
    return (l == HEAD) || (l == HEADTAIL);
  endfunction

  function automatic logic is_tail(input flit_label_t l);
    return (l == TAIL) || (l == HEADTAIL);
  endfunction

endpackage

// File: rtl/vc_buffer_ctrl.sv
// Per-VC read-side controller for one input-port circular buffer.
// Detects a head flit, latches its route, obtains a downstream VC through VC
// allocation, then forwards the packet flit by flit under switch-allocation grants.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   buf_data_i/buf_is_empty_i/buf_read_o   buffer front, empty flag, pop strobe
//   route_i                  route of the current front head flit
//   va_req_o/va_port_o/va_grant_i/va_vc_i  VC allocation handshake
//   sa_req_o/sa_port_o/sa_grant_i          switch allocation handshake
//   credit_avail_i           downstream VC has a credit
//   flit_o/flit_valid_o      flit to the crossbar, tagged with the allocated VC
//   vc_state_o/pkt_flits_o/error_o         state, packet flit count, sticky error
module vc_buffer_ctrl
  import noc_params::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  flit_novc_t           buf_data_i,
  input  logic                 buf_is_empty_i,
  output logic                 buf_read_o,
  input  port_t                route_i,
  output logic                 va_req_o,
  output port_t                va_port_o,
  input  logic                 va_grant_i,
  input  vc_id_t               va_vc_i,
  output logic                 sa_req_o,
  output port_t                sa_port_o,
  input  logic                 sa_grant_i,
  input  logic                 credit_avail_i,
  output flit_t                flit_o,
  output logic                 flit_valid_o,
  output vc_state_t            vc_state_o,
  output logic [PKT_CNT_W-1:0] pkt_flits_o,
  output logic                 error_o
);

  localparam logic [PKT_CNT_W-1:0] CNT_MAX = PKT_CNT_W'(MAX_PKT_FLITS);

  vc_state_t            state_q, state_d;
  port_t                port_q, port_d;
  vc_id_t               vc_q, vc_d;
  logic [PKT_CNT_W-1:0] cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic                 front_valid;

  assign front_valid = !buf_is_empty_i;

  // State and latch registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      port_q  <= '0;
      vc_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      vc_q    <= vc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state and combinational handshake outputs
  always_comb begin
    state_d      = state_q;
    port_d       = port_q;
    vc_d         = vc_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    va_req_o     = 1'b0;
    sa_req_o     = 1'b0;
    buf_read_o   = 1'b0;
    flit_valid_o = 1'b0;
    flit_o       = '0;

    // Strobes stay quiet while reset is held so a stale buffer front is not popped.
    if (rst) begin
      unique case (state_q)
        IDLE: begin
          if (front_valid) begin
            if (is_head(buf_data_i.label)) begin
              port_d  = route_i;
              cnt_d   = '0;
              state_d = VA;
            end else begin
              // Orphan body/tail: discard it without forwarding.
              buf_read_o = 1'b1;
              err_d      = 1'b1;
            end
          end
        end
        VA: begin
          va_req_o = 1'b1;
          if (va_grant_i) begin
            vc_d    = va_vc_i;
            state_d = ACTIVE;
          end
        end
        ACTIVE: begin
          sa_req_o = front_valid & credit_avail_i;
          if (sa_grant_i && sa_req_o) begin
            buf_read_o   = 1'b1;
            flit_valid_o = 1'b1;
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
            // A head after the first flit means the previous packet lost its tail.
            if (is_head(buf_data_i.label) && (cnt_q != '0)) err_d = 1'b1;
            if (is_tail(buf_data_i.label)) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase

      if (sa_grant_i && !sa_req_o) err_d = 1'b1;
      if (va_grant_i && (state_q != VA)) err_d = 1'b1;
    end

    if (flit_valid_o) begin
      flit_o.label = buf_data_i.label;
      flit_o.vc_id = vc_q;
      flit_o.data  = buf_data_i.data;
    end
  end

  assign va_port_o   = port_q;
  assign sa_port_o   = port_q;
  assign vc_state_o  = state_q;
  assign pkt_flits_o = cnt_q;
  assign error_o     = err_q;

endmodule

// File: tb/tb_vc_buffer_ctrl.sv
// Self-checking bench for vc_buffer_ctrl: a queue models the circular buffer,
// a scoreboard queue holds the flits expected at the crossbar output.
module tb_vc_buffer_ctrl;
  import noc_params::*;

  logic                 clk = 1'b0;
  logic                 rst;
  flit_novc_t           buf_data_i;
  logic                 buf_is_empty_i;
  logic                 buf_read_o;
  port_t                route_i;
  logic                 va_req_o;
  port_t                va_port_o;
  logic                 va_grant_i;
  vc_id_t               va_vc_i;
  logic                 sa_req_o;
  port_t                sa_port_o;
  logic                 sa_grant_i;
  logic                 credit_avail_i;
  flit_t                flit_o;
  logic                 flit_valid_o;
  vc_state_t            vc_state_o;
  logic [PKT_CNT_W-1:0] pkt_flits_o;
  logic                 error_o;

  logic va_manual, va_auto, sa_manual, sa_auto;

  flit_novc_t buf_q[$];
  flit_t      exp_q[$];
  int checks = 0;
  int errors = 0;
  int va_req_cycles = 0;
  int n;

  always #5 clk = ~clk;

  // Allocator models: either a forced grant or a grant that follows the request.
  assign va_grant_i = va_manual | (va_auto & va_req_o);
  assign sa_grant_i = sa_manual | (sa_auto & sa_req_o);

  vc_buffer_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .buf_data_i     (buf_data_i),
    .buf_is_empty_i (buf_is_empty_i),
    .buf_read_o     (buf_read_o),
    .route_i        (route_i),
    .va_req_o       (va_req_o),
    .va_port_o      (va_port_o),
    .va_grant_i     (va_grant_i),
    .va_vc_i        (va_vc_i),
    .sa_req_o       (sa_req_o),
    .sa_port_o      (sa_port_o),
    .sa_grant_i     (sa_grant_i),
    .credit_avail_i (credit_avail_i),
    .flit_o         (flit_o),
    .flit_valid_o   (flit_valid_o),
    .vc_state_o     (vc_state_o),
    .pkt_flits_o    (pkt_flits_o),
    .error_o        (error_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic refresh_buf();
    buf_is_empty_i = (buf_q.size() == 0);
    buf_data_i     = (buf_q.size() != 0) ? buf_q[0] : '0;
  endtask

  task automatic push_flit(input flit_label_t l, input logic [15:0] d,
                           input logic expect_out, input vc_id_t vc);
    flit_novc_t f;
    flit_t      e;
    f.label = l;
    f.data  = d;
    buf_q.push_back(f);
    if (expect_out) begin
      e.label = l;
      e.vc_id = vc;
      e.data  = d;
      exp_q.push_back(e);
    end
    refresh_buf();
  endtask

  // One clock: monitor at the falling edge, buffer pop just after the rising edge.
  task automatic tick();
    logic  rd;
    flit_t e;
    @(negedge clk);
    rd = buf_read_o;
    if (va_req_o) va_req_cycles++;
    if (buf_read_o) check("read_while_empty", 32'(buf_is_empty_i), 0);
    if (flit_valid_o) begin
      check("valid_without_read", 32'(buf_read_o), 1);
      if (exp_q.size() == 0) begin
        check("unexpected_flit", 32'(flit_valid_o), 0);
      end else begin
        e = exp_q.pop_front();
        check("flit_o", 32'(flit_o), 32'(e));
      end
    end
    @(posedge clk);
    #1;
    if (rd && buf_q.size() != 0) buf_q.delete(0);
    refresh_buf();
  endtask

  task automatic wait_idle(input string tag, input int budget, output int cycles);
    cycles = 0;
    while (!(vc_state_o == IDLE && buf_q.size() == 0) && cycles < budget) begin
      tick();
      cycles++;
    end
    check({tag, "_timeout"}, 32'(cycles < budget), 1);
  endtask

  task automatic wait_count(input string tag, input int cnt, input int budget);
    int c;
    c = 0;
    while (32'(pkt_flits_o) != cnt && c < budget) begin
      tick();
      c++;
    end
    check({tag, "_timeout"}, 32'(c < budget), 1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    buf_q.delete();
    exp_q.delete();
    refresh_buf();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    route_i = '0;
    va_vc_i = '0;
    credit_avail_i = 1'b0;
    va_manual = 1'b0; va_auto = 1'b0; sa_manual = 1'b0; sa_auto = 1'b0;
    refresh_buf();
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check("rst_state", 32'(vc_state_o), 32'(IDLE));
    check("rst_va_req", 32'(va_req_o), 0);
    check("rst_sa_req", 32'(sa_req_o), 0);
    check("rst_read", 32'(buf_read_o), 0);
    check("rst_valid", 32'(flit_valid_o), 0);
    check("rst_ports", 32'({va_port_o, sa_port_o}), 0);
    check("rst_pkt", 32'(pkt_flits_o), 0);
    check("rst_error", 32'(error_o), 0);
    check("rst_flit", 32'(flit_o), 0);
    rst = 1'b1;
    va_req_cycles = 0;
    repeat (10) tick();
    check("idle_error", 32'(error_o), 0);
    check("idle_state", 32'(vc_state_o), 32'(IDLE));
    check("idle_va_req", 32'(va_req_cycles), 0);

    // HEAD/BODY/TAIL with a delayed VC grant
    route_i = 3'd2; credit_avail_i = 1'b1; sa_auto = 1'b1; va_vc_i = 1'b1;
    push_flit(HEAD, 16'hA001, 1'b1, 1'b1);
    push_flit(BODY, 16'hA002, 1'b1, 1'b1);
    push_flit(TAIL, 16'hA003, 1'b1, 1'b1);
    #1;
    check("p1_idle_state", 32'(vc_state_o), 32'(IDLE));
    check("p1_head_not_popped", 32'(buf_read_o), 0);
    va_req_cycles = 0;
    tick();
    route_i = 3'd0;
    check("p1_va_state", 32'(vc_state_o), 32'(VA));
    check("p1_va_port", 32'(va_port_o), 2);
    tick();
    tick();
    va_manual = 1'b1;
    #1;
    check("p1_va_req", 32'(va_req_o), 1);
    tick();
    va_manual = 1'b0;
    check("p1_active", 32'(vc_state_o), 32'(ACTIVE));
    check("p1_sa_port", 32'(sa_port_o), 2);
    #1;
    check("p1_sa_req", 32'(sa_req_o), 1);
    check("p1_first_valid", 32'(flit_valid_o), 1);
    wait_idle("p1", 20, n);
    check("p1_pkt_flits", 32'(pkt_flits_o), 3);
    check("p1_va_cycles", 32'(va_req_cycles), 3);
    check("p1_scoreboard", 32'(exp_q.size()), 0);
    check("p1_error", 32'(error_o), 0);

    // Single HEADTAIL with immediate grants
    va_auto = 1'b1; va_vc_i = 1'b0; route_i = 3'd4;
    push_flit(HEADTAIL, 16'hB00B, 1'b1, 1'b0);
    wait_idle("ht", 10, n);
    check("ht_latency", 32'(n), 3);
    check("ht_pkt_flits", 32'(pkt_flits_o), 1);
    check("ht_sa_port", 32'(sa_port_o), 4);
    check("ht_scoreboard", 32'(exp_q.size()), 0);

    // Credit stall mid-packet
    va_vc_i = 1'b1; route_i = 3'd1;
    push_flit(HEAD, 16'hC001, 1'b1, 1'b1);
    push_flit(BODY, 16'hC002, 1'b1, 1'b1);
    push_flit(BODY, 16'hC003, 1'b1, 1'b1);
    push_flit(TAIL, 16'hC004, 1'b1, 1'b1);
    wait_count("cr", 2, 20);
    credit_avail_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("cr_sa_req", 32'(sa_req_o), 0);
      check("cr_read", 32'(buf_read_o), 0);
      check("cr_state", 32'(vc_state_o), 32'(ACTIVE));
      tick();
    end
    check("cr_pkt_hold", 32'(pkt_flits_o), 2);
    credit_avail_i = 1'b1;
    wait_idle("cr", 20, n);
    check("cr_pkt_flits", 32'(pkt_flits_o), 4);
    check("cr_scoreboard", 32'(exp_q.size()), 0);

    // Buffer runs empty mid-packet
    push_flit(HEAD, 16'hD001, 1'b1, 1'b1);
    wait_count("em", 1, 20);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("em_sa_req", 32'(sa_req_o), 0);
      check("em_state", 32'(vc_state_o), 32'(ACTIVE));
      tick();
    end
    push_flit(TAIL, 16'hD002, 1'b1, 1'b1);
    wait_idle("em", 10, n);
    check("em_pkt_flits", 32'(pkt_flits_o), 2);
    check("em_error", 32'(error_o), 0);

    // Reset in ACTIVE after 2 of 4 flits
    push_flit(HEAD, 16'hE001, 1'b1, 1'b1);
    push_flit(BODY, 16'hE002, 1'b1, 1'b1);
    push_flit(BODY, 16'hE003, 1'b1, 1'b1);
    push_flit(TAIL, 16'hE004, 1'b1, 1'b1);
    wait_count("mr", 2, 20);
    rst = 1'b0;
    buf_q.delete();
    exp_q.delete();
    refresh_buf();
    #1;
    check("mr_state", 32'(vc_state_o), 32'(IDLE));
    check("mr_outs", 32'({va_req_o, sa_req_o, buf_read_o, flit_valid_o}), 0);
    check("mr_pkt", 32'(pkt_flits_o), 0);
    check("mr_flit", 32'(flit_o), 0);
    check("mr_port", 32'(va_port_o), 0);
    tick();
    rst = 1'b1;
    va_auto = 1'b0;
    push_flit(HEAD, 16'hE101, 1'b1, 1'b1);
    #1;
    check("mr_va_req_early", 32'(va_req_o), 0);
    tick();
    #1;
    check("mr_va_req", 32'(va_req_o), 1);
    va_auto = 1'b1;
    push_flit(TAIL, 16'hE102, 1'b1, 1'b1);
    wait_idle("mr", 10, n);
    check("mr_pkt_flits", 32'(pkt_flits_o), 2);
    check("mr_error", 32'(error_o), 0);

    // Orphan BODY in IDLE is dropped and flags an error
    push_flit(BODY, 16'hF001, 1'b0, 1'b0);
    #1;
    check("ob_read", 32'(buf_read_o), 1);
    check("ob_valid", 32'(flit_valid_o), 0);
    tick();
    check("ob_error", 32'(error_o), 1);
    check("ob_drained", 32'(buf_q.size()), 0);
    check("ob_state", 32'(vc_state_o), 32'(IDLE));
    repeat (3) tick();
    check("ob_error_sticky", 32'(error_o), 1);
    rst = 1'b0;
    #1;
    check("ob_error_clear", 32'(error_o), 0);
    rst = 1'b1;

    // VA grant outside VA
    va_auto = 1'b0;
    va_manual = 1'b1;
    tick();
    va_manual = 1'b0;
    check("vg_error", 32'(error_o), 1);
    check("vg_state", 32'(vc_state_o), 32'(IDLE));
    do_reset();

    // SA grant without a request
    sa_manual = 1'b1;
    #1;
    check("sg_read", 32'(buf_read_o), 0);
    tick();
    sa_manual = 1'b0;
    check("sg_error", 32'(error_o), 1);
    do_reset();

    // HEAD arriving before the tail
    va_auto = 1'b1;
    push_flit(HEAD, 16'h1001, 1'b1, 1'b1);
    push_flit(HEAD, 16'h1002, 1'b1, 1'b1);
    push_flit(TAIL, 16'h1003, 1'b1, 1'b1);
    wait_idle("hh", 20, n);
    check("hh_pkt_flits", 32'(pkt_flits_o), 3);
    check("hh_error", 32'(error_o), 1);
    check("hh_scoreboard", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
